// File: rtl/privilege_sequencer.sv
// Privileged-mode sequencer: injects ENTER/EXIT micro-ops into the register bank's control stream.
// Optional IRQ mask register is built when PRIV_IRQ_MASK_EN is defined.
module privilege_sequencer #(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             IRQ_COUNT      = 4,
    parameter logic [ADDR_WIDTH-1:0]   VECTOR_BASE    = 32'h0000_0010,
    parameter int unsigned             SPECREG_LENGTH = 4
) (
    input  logic                      slow_clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [IRQ_COUNT-1:0]      irq_request,
    input  logic                      return_request,
`ifdef PRIV_IRQ_MASK_EN
    input  logic                      mask_write,
    input  logic [IRQ_COUNT-1:0]      mask_data,
`endif
    input  logic [2:0]                core_control,
    input  logic                      core_should_branch,
    output logic [2:0]                control,
    output logic                      should_branch,
    output logic [ADDR_WIDTH-1:0]     branch_target,
    output logic                      inject,
    output logic                      privileged_mode,
    output logic [SPECREG_LENGTH-1:0] special_register,
    output logic [IRQ_COUNT-1:0]      irq_ack
);

    typedef enum logic [1:0] {
        USER  = 2'd0,
        ENTER = 2'd1,
        PRIV  = 2'd2,
        EXIT  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [SPECREG_LENGTH-1:0] cause_q, cause_d;
    logic                      priv_q, priv_d;
    logic [IRQ_COUNT-1:0]      ack_q, ack_d;
    logic [IRQ_COUNT-1:0]      eligible;
    logic [SPECREG_LENGTH-1:0] irq_cause;
    logic                      cause_is_trap;

`ifdef PRIV_IRQ_MASK_EN
    logic [IRQ_COUNT-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (mask_write && priv_q) begin
            mask_d = mask_data;
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign eligible = irq_request & ~mask_q;
`else
    assign eligible = irq_request;
`endif

    // Trap cause is all-ones; IRQ causes are index+1, so they never collide.
    assign cause_is_trap = (cause_q == '1);

    // Scan high-to-low so the lowest pending index is the last one written.
    always_comb begin
        irq_cause = '0;
        for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
            if (eligible[IRQ_COUNT-1-i]) begin
                irq_cause = SPECREG_LENGTH'(IRQ_COUNT - i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_d   = '0;
        if (enable) begin
            case (state_q)
                USER: begin
                    if (core_control == 3'd4) begin
                        cause_d = '1;
                        state_d = ENTER;
                    end else if (|eligible) begin
                        cause_d = irq_cause;
                        state_d = ENTER;
                    end
                end
                ENTER: begin
                    state_d = PRIV;
                    if (!cause_is_trap) begin
                        for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
                            ack_d[i] = (cause_q == SPECREG_LENGTH'(i + 1));
                        end
                    end
                end
                PRIV: begin
                    if (return_request) begin
                        state_d = EXIT;
                    end
                end
                EXIT: begin
                    state_d = USER;
                end
                default: state_d = USER;
            endcase
        end
        priv_d = (state_d == PRIV) || (state_d == EXIT);
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= USER;
            cause_q <= '0;
            priv_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            priv_q  <= priv_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        control       = core_control;
        should_branch = core_should_branch;
        inject        = 1'b0;
        branch_target = '0;
        case (state_q)
            USER: begin
                if (core_control == 3'd5 || core_control == 3'd4) begin
                    control = 3'd0;
                end
            end
            ENTER: begin
                inject        = 1'b1;
                control       = 3'd4;
                should_branch = 1'b1;
                branch_target = cause_is_trap ? VECTOR_BASE
                                              : VECTOR_BASE + ADDR_WIDTH'(cause_q);
            end
            PRIV: begin
                if (core_control == 3'd4) begin
                    control = 3'd0;
                end
            end
            EXIT: begin
                inject        = 1'b1;
                control       = 3'd5;
                should_branch = 1'b0;
            end
            default: ;
        endcase
    end

    assign privileged_mode  = priv_q;
    assign special_register = cause_q;
    assign irq_ack          = ack_q;

endmodule

// File: tb/tb_privilege_sequencer.sv
// Directed scoreboard bench for privilege_sequencer; mask tests build with PRIV_IRQ_MASK_EN.
module tb_privilege_sequencer;

    logic        slow_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  irq_request;
    logic        return_request;
    logic [2:0]  core_control;
    logic        core_should_branch;
    logic [2:0]  control;
    logic        should_branch;
    logic [31:0] branch_target;
    logic        inject;
    logic        privileged_mode;
    logic [3:0]  special_register;
    logic [3:0]  irq_ack;
`ifdef PRIV_IRQ_MASK_EN
    logic        mask_write;
    logic [3:0]  mask_data;
`endif

    int checks   = 0;
    int failures = 0;

    localparam int S_CTL = 0, S_SB = 1, S_BT = 2, S_INJ = 3, S_PRIV = 4, S_SPEC = 5, S_ACK = 6;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    privilege_sequencer #(
        .ADDR_WIDTH(32),
        .IRQ_COUNT(4),
        .VECTOR_BASE(32'h0000_0010),
        .SPECREG_LENGTH(4)
    ) dut (
        .slow_clock(slow_clock),
        .reset(reset),
        .enable(enable),
        .irq_request(irq_request),
        .return_request(return_request),
`ifdef PRIV_IRQ_MASK_EN
        .mask_write(mask_write),
        .mask_data(mask_data),
`endif
        .core_control(core_control),
        .core_should_branch(core_should_branch),
        .control(control),
        .should_branch(should_branch),
        .branch_target(branch_target),
        .inject(inject),
        .privileged_mode(privileged_mode),
        .special_register(special_register),
        .irq_ack(irq_ack)
    );

    always #5 slow_clock = ~slow_clock;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic void push(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endfunction

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_CTL:   return {29'd0, control};
            S_SB:    return {31'd0, should_branch};
            S_BT:    return branch_target;
            S_INJ:   return {31'd0, inject};
            S_PRIV:  return {31'd0, privileged_mode};
            S_SPEC:  return {28'd0, special_register};
            default: return {28'd0, irq_ack};
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic [2:0] cc, input logic sbr, input logic [3:0] irq,
                         input logic ret, input logic en);
        core_control       = cc;
        core_should_branch = sbr;
        irq_request        = irq;
        return_request     = ret;
        enable             = en;
    endtask

    // Inputs change at the falling edge, outputs are checked 1ns later, then one clock passes.
    task automatic step(input logic [2:0] cc, input logic sbr, input logic [3:0] irq,
                        input logic ret, input logic en);
        drive(cc, sbr, irq, ret, en);
        #1;
        drain();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    initial begin
        reset = 1'b1;
`ifdef PRIV_IRQ_MASK_EN
        mask_write = 1'b0;
        mask_data  = '0;
`endif
        drive(3'd3, 1'b1, 4'b0000, 1'b0, 1'b1);
        @(negedge slow_clock);
        push("rst_priv", S_PRIV, 0);
        push("rst_spec", S_SPEC, 0);
        push("rst_ack", S_ACK, 0);
        push("rst_inj", S_INJ, 0);
        push("rst_ctl", S_CTL, 3);
        push("rst_sb", S_SB, 1);
        push("rst_bt", S_BT, 0);
        drain();
        reset = 1'b0;

        push("s1_ctl", S_CTL, 2);
        push("s1_inj", S_INJ, 0);
        step(3'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("user_cc5_ctl", S_CTL, 0);
        step(3'd5, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("irq_step_ctl", S_CTL, 1);
        push("irq_step_inj", S_INJ, 0);
        step(3'd1, 1'b0, 4'b0100, 1'b0, 1'b1);
        push("enter_inj", S_INJ, 1);
        push("enter_ctl", S_CTL, 4);
        push("enter_sb", S_SB, 1);
        push("enter_bt", S_BT, 32'h13);
        push("enter_priv", S_PRIV, 0);
        push("enter_ack", S_ACK, 0);
        step(3'd0, 1'b0, 4'b0100, 1'b0, 1'b1);
        push("priv_on", S_PRIV, 1);
        push("priv_spec", S_SPEC, 3);
        push("irq2_ack", S_ACK, 4'b0100);
        push("priv_cc4_ctl", S_CTL, 0);
        push("priv_inj", S_INJ, 0);
        push("priv_bt", S_BT, 0);
        step(3'd4, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("ack_pulse_end", S_ACK, 0);
        push("priv_pass_ctl", S_CTL, 3);
        push("priv_hold", S_PRIV, 1);
        step(3'd3, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("priv_nest_ack", S_ACK, 0);
        push("priv_nest_inj", S_INJ, 0);
        push("ret_ctl", S_CTL, 2);
        push("ret_sb", S_SB, 1);
        step(3'd2, 1'b1, 4'b0001, 1'b1, 1'b1);
        push("exit_inj", S_INJ, 1);
        push("exit_ctl", S_CTL, 5);
        push("exit_sb", S_SB, 0);
        push("exit_priv", S_PRIV, 1);
        push("exit_ack", S_ACK, 0);
        step(3'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
        push("user_priv", S_PRIV, 0);
        push("user_ctl", S_CTL, 6);
        push("user_sb", S_SB, 1);
        push("user_inj", S_INJ, 0);
        push("user_spec_kept", S_SPEC, 3);
        step(3'd6, 1'b1, 4'b0000, 1'b0, 1'b1);

        push("trap_ctl", S_CTL, 0);
        push("trap_inj", S_INJ, 0);
        step(3'd4, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("trap_enter_inj", S_INJ, 1);
        push("trap_enter_bt", S_BT, 32'h10);
        push("trap_enter_ctl", S_CTL, 4);
        push("trap_spec", S_SPEC, 4'hF);
        step(3'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("trap_no_ack", S_ACK, 0);
        push("trap_priv", S_PRIV, 1);
        step(3'd0, 1'b0, 4'b0001, 1'b1, 1'b1);
        push("trap_exit_ctl", S_CTL, 5);
        step(3'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("post_trap_priv", S_PRIV, 0);
        push("post_trap_inj", S_INJ, 0);
        step(3'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("irq0_bt", S_BT, 32'h11);
        push("irq0_inj", S_INJ, 1);
        step(3'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        push("irq0_ack", S_ACK, 4'b0001);
        push("irq0_spec", S_SPEC, 1);
        step(3'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
        push("irq0_exit_inj", S_INJ, 1);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("irq0_user_priv", S_PRIV, 0);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            push($sformatf("hold%0d_inj", i), S_INJ, 0);
            push($sformatf("hold%0d_priv", i), S_PRIV, 0);
            push($sformatf("hold%0d_spec", i), S_SPEC, 1);
            push($sformatf("hold%0d_ack", i), S_ACK, 0);
            step(3'd0, 1'b0, 4'b0010, 1'b0, 1'b0);
        end
        push("hold_release_inj", S_INJ, 0);
        step(3'd0, 1'b0, 4'b0010, 1'b0, 1'b1);
        drive(3'd0, 1'b0, 4'b0010, 1'b0, 1'b1);
        push("irq1_enter_inj", S_INJ, 1);
        push("irq1_enter_bt", S_BT, 32'h12);
        push("irq1_spec", S_SPEC, 2);
        #1;
        drain();
        reset = 1'b1;
        #1;
        push("arst_inj", S_INJ, 0);
        push("arst_ctl", S_CTL, 0);
        push("arst_spec", S_SPEC, 0);
        push("arst_priv", S_PRIV, 0);
        push("arst_bt", S_BT, 0);
        drain();
        @(posedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b0;
        push("arst_after_ack", S_ACK, 0);
        push("arst_after_priv", S_PRIV, 0);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("arst_after2_ack", S_ACK, 0);
        push("arst_after2_inj", S_INJ, 0);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);

`ifdef PRIV_IRQ_MASK_EN
        step(3'd4, 1'b0, 4'b0000, 1'b0, 1'b1);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        mask_write = 1'b1;
        mask_data  = 4'b0001;
        push("mask_priv", S_PRIV, 1);
        step(3'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
        mask_write = 1'b0;
        mask_data  = 4'b0000;
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        push("mask_user_inj", S_INJ, 0);
        step(3'd0, 1'b0, 4'b0011, 1'b0, 1'b1);
        push("mask_enter_bt", S_BT, 32'h12);
        push("mask_enter_inj", S_INJ, 1);
        step(3'd0, 1'b0, 4'b0011, 1'b0, 1'b1);
        push("mask_spec", S_SPEC, 2);
        push("mask_ack", S_ACK, 4'b0010);
        step(3'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
